// File: rtl/mem_word_access_pkg.sv
// Shared types and lane helpers for the byte-address to word-memory access unit.
package mem_word_access_pkg;

  localparam int unsigned WORD_SHIFT = 2;
  localparam int unsigned LANES      = 4;
  localparam int unsigned WORD_W     = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  // Size 11 is never legal; half and word must sit on their natural boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [LANES-1:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [LANES-1:0] base;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      SZ_WORD: base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << off;
  endfunction

  function automatic logic [WORD_W-1:0] store_wdata(input logic [1:0] size,
                                                     input logic [WORD_W-1:0] wdata);
    logic [WORD_W-1:0] rep;
    case (size)
      SZ_BYTE: rep = {4{wdata[7:0]}};
      SZ_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/mem_word_access_load_extend.sv
// Combinational load lane extraction: shift the addressed lane down, then sign/zero extend.
module mem_word_access_load_extend
  import mem_word_access_pkg::*;
(
  input  logic [WORD_W-1:0] rdata_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [WORD_W-1:0] data_c
);

  logic [WORD_W-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_c = {{24{signed_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_c = {{16{signed_i & shifted[15]}}, shifted[15:0]};
      default: data_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_word_access.sv
// Load/store lane unit between the MEM stage and word-organised data memory.
// Single outstanding request; every output is driven straight from a register.
module mem_word_access
  import mem_word_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [1:0]                   req_size,
  input  logic                         req_signed,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         mem_en,
  output logic [LANES-1:0]             mem_be,
  output logic [ADDR_W-WORD_SHIFT-1:0] mem_waddr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_ack,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_fault
);

  state_e                      state_q, state_d;
  logic                        req_ready_q, req_ready_d;
  logic                        mem_en_q, mem_en_d;
  logic [LANES-1:0]            mem_be_q, mem_be_d;
  logic [ADDR_W-WORD_SHIFT-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]           rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_fault_q, rsp_fault_d;
  logic                        we_q, we_d;
  logic [1:0]                  size_q, size_d;
  logic                        signed_q, signed_d;
  logic [1:0]                  off_q, off_d;
  logic [DATA_W-1:0]           ext_c;

  mem_word_access_load_extend u_load_extend (
    .rdata_i  (mem_rdata),
    .offset_i (off_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_c   (ext_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_en_q    <= mem_en_d;
      mem_be_q    <= mem_be_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
    end
  end

  // Next-state logic; the response is registered on the transition that produces it.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_en_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          size_d      = req_size;
          signed_d    = req_signed;
          off_d       = req_addr[1:0];
          mem_waddr_d = req_addr[ADDR_W-1:WORD_SHIFT];
          mem_wdata_d = store_wdata(req_size, req_wdata);
          mem_be_d    = req_we ? store_be(req_size, req_addr[1:0]) : '0;
          req_ready_d = 1'b0;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d     = ST_FAULT;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = ST_ACCESS;
            mem_en_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        mem_en_d = 1'b1;
        if (mem_ack) begin
          mem_en_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b0;
          rsp_rdata_d = we_q ? '0 : ext_c;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_FAULT: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign req_ready = req_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_be    = mem_be_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_word_access.sv
// Directed-vector bench for mem_word_access with hand-computed expectations.
module tb_mem_word_access;
  import mem_word_access_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_en;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;

  int unsigned n_cmp;
  int unsigned n_err;

  mem_word_access #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_en     (mem_en),
    .mem_be     (mem_be),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // Aligned load with ack in the first ACCESS cycle; leaves the bench in the response cycle.
  task automatic do_load(input string tag, input logic sgn, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp);
    drive_req(1'b0, size, sgn, addr, 32'h0);
    tick();
    req_valid = 1'b0;
    check_eq({tag, " mem_en"}, 32'(mem_en), 32'd1);
    check_eq({tag, " mem_be"}, 32'(mem_be), 32'd0);
    check_eq({tag, " mem_waddr"}, 32'(mem_waddr), addr >> 2);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check_eq({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, " rsp_fault"}, 32'(rsp_fault), 32'd0);
    check_eq({tag, " rsp_rdata"}, rsp_rdata, exp);
    check_eq({tag, " req_ready"}, 32'(req_ready), 32'd1);
  endtask

  logic [31:0] exp_b [4];
  logic [1:0]  bad_size [3];
  logic [31:0] bad_addr [3];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    exp_b    = '{32'h44, 32'h33, 32'h22, 32'h11};
    bad_size = '{SZ_WORD, SZ_HALF, 2'b11};
    bad_addr = '{32'h6, 32'h101, 32'h0};

    tick();
    tick();
    check_eq("rst mem_en", 32'(mem_en), 32'd0);
    check_eq("rst mem_be", 32'(mem_be), 32'd0);
    check_eq("rst mem_waddr", 32'(mem_waddr), 32'd0);
    check_eq("rst mem_wdata", mem_wdata, 32'd0);
    check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst rsp_fault", 32'(rsp_fault), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst req_ready", 32'(req_ready), 32'd1);

    // Stray ack in IDLE must not produce anything
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("idle ack rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("idle ack mem_en", 32'(mem_en), 32'd0);

    // Store byte 0xA5 at 0x13, immediate ack
    drive_req(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hA5);
    tick();
    req_valid = 1'b0;
    check_eq("sb mem_en", 32'(mem_en), 32'd1);
    check_eq("sb mem_waddr", 32'(mem_waddr), 32'h4);
    check_eq("sb mem_be", 32'(mem_be), 32'b1000);
    check_eq("sb mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    check_eq("sb req_ready", 32'(req_ready), 32'd0);
    check_eq("sb early rsp", 32'(rsp_valid), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("sb rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("sb rsp_fault", 32'(rsp_fault), 32'd0);
    check_eq("sb rsp_rdata", rsp_rdata, 32'd0);
    check_eq("sb mem_en off", 32'(mem_en), 32'd0);
    tick();
    check_eq("sb rsp pulse", 32'(rsp_valid), 32'd0);

    // Half loads at 0x102 of 0x8001_7FFF
    do_load("lh", 1'b1, SZ_HALF, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
    do_load("lhu", 1'b0, SZ_HALF, 32'h102, 32'h8001_7FFF, 32'h0000_8001);
    tick();
    check_eq("lhu rsp pulse", 32'(rsp_valid), 32'd0);

    // Misaligned word, misaligned half, illegal size: all fault without a memory strobe
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, bad_size[i], 1'b0, bad_addr[i], 32'h0);
      tick();
      req_valid = 1'b0;
      check_eq("flt rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("flt rsp_fault", 32'(rsp_fault), 32'd1);
      check_eq("flt rsp_rdata", rsp_rdata, 32'd0);
      check_eq("flt mem_en", 32'(mem_en), 32'd0);
      tick();
      check_eq("flt rsp pulse", 32'(rsp_valid), 32'd0);
      check_eq("flt mem_en after", 32'(mem_en), 32'd0);
      check_eq("flt req_ready", 32'(req_ready), 32'd1);
    end

    // Word store, ack after 3 ACCESS cycles; a request held during ACCESS is ignored
    drive_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEAD_BEEF);
    tick();
    req_addr  = 32'h44;
    req_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      check_eq("sw mem_en", 32'(mem_en), 32'd1);
      check_eq("sw mem_be", 32'(mem_be), 32'hF);
      check_eq("sw mem_waddr", 32'(mem_waddr), 32'h8);
      check_eq("sw mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check_eq("sw req_ready", 32'(req_ready), 32'd0);
      check_eq("sw early rsp", 32'(rsp_valid), 32'd0);
      if (i == 2) begin
        req_valid = 1'b0;
        mem_ack   = 1'b1;
      end
      tick();
    end
    mem_ack = 1'b0;
    check_eq("sw rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("sw rsp_fault", 32'(rsp_fault), 32'd0);
    check_eq("sw rsp_rdata", rsp_rdata, 32'd0);
    check_eq("sw mem_en off", 32'(mem_en), 32'd0);
    tick();
    check_eq("sw rsp pulse", 32'(rsp_valid), 32'd0);
    check_eq("sw no reaccept", 32'(mem_en), 32'd0);

    // Reset in the middle of an access abandons it
    drive_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    tick();
    req_valid = 1'b0;
    check_eq("rstacc mem_en", 32'(mem_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstacc mem_en drop", 32'(mem_en), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rstacc rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rstacc mem_en idle", 32'(mem_en), 32'd0);
    check_eq("rstacc req_ready", 32'(req_ready), 32'd1);
    tick();
    check_eq("rstacc rsp_valid2", 32'(rsp_valid), 32'd0);

    // Back-to-back byte loads over word 0x1122_3344
    for (int i = 0; i < 4; i++)
      do_load("lbu", 1'b0, SZ_BYTE, 32'h100 + 32'(i), 32'h1122_3344, exp_b[i]);
    for (int i = 0; i < 4; i++)
      do_load("lb", 1'b1, SZ_BYTE, 32'h100 + 32'(i), 32'h1122_3344, exp_b[i]);
    do_load("lb neg", 1'b1, SZ_BYTE, 32'h103, 32'h8022_3344, 32'hFFFF_FF80);
    do_load("lbu top", 1'b0, SZ_BYTE, 32'h103, 32'h8022_3344, 32'h0000_0080);
    do_load("lw", 1'b1, SZ_WORD, 32'h200, 32'h8765_4321, 32'h8765_4321);
    tick();
    check_eq("end rsp pulse", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
